// File: rtl/crc_code_scrubber_if.sv
`default_nettype none
// ============================================================================
//  Module      : crc_code_scrubber_if
//  Description : Control, status and memory read-port bundle for the CRC
//                code scrubber.
//                master : host/memory side (drives start, stop, mem_busy,
//                         rd_data; observes everything else)
//                slave  : scrubber side (drives rd_en, rd_addr and all
//                         scrub/error status outputs)
//  Signals     : start, stop, mem_busy, rd_en, rd_addr[ADDR_W],
//                rd_data[DATA_W+CRC_W], scrub_busy, scrub_done, err_pulse,
//                err_addr[ADDR_W], err_syndrome[CRC_W], err_count[5]
//  Revision    : 1.0 - initial release
// ============================================================================
interface crc_code_scrubber_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CRC_W  = 4
);
    logic                      start;
    logic                      stop;
    logic                      mem_busy;
    logic                      rd_en;
    logic [ADDR_W-1:0]         rd_addr;
    logic [DATA_W+CRC_W-1:0]   rd_data;
    logic                      scrub_busy;
    logic                      scrub_done;
    logic                      err_pulse;
    logic [ADDR_W-1:0]         err_addr;
    logic [CRC_W-1:0]          err_syndrome;
    logic [4:0]                err_count;

    modport master (
        output start, stop, mem_busy, rd_data,
        input  rd_en, rd_addr, scrub_busy, scrub_done,
               err_pulse, err_addr, err_syndrome, err_count
    );

    modport slave (
        input  start, stop, mem_busy, rd_data,
        output rd_en, rd_addr, scrub_busy, scrub_done,
               err_pulse, err_addr, err_syndrome, err_count
    );
endinterface
`default_nettype wire

// File: rtl/crc_code_scrubber.sv
`default_nettype none
// ============================================================================
//  Module      : crc_code_scrubber
//  Description : Background scrubber for a CRC-4 protected word store. Walks
//                every address, reads each codeword through the shared read
//                port (yielding while mem_busy is high), recomputes the CRC
//                bit-serially MSB first and reports every word that leaves a
//                non-zero remainder.
//  Ports       : clk, rst (synchronous, active high)
//                bus (crc_code_scrubber_if.slave):
//                  in : start, stop, mem_busy, rd_data
//                  out: rd_en, rd_addr, scrub_busy, scrub_done, err_pulse,
//                       err_addr, err_syndrome, err_count
//  Options     : CRC_SCRUB_CONTINUOUS_EN - when defined the scrubber wraps
//                from the last address straight back to address 0 and keeps
//                going until stop or rst; err_count accumulates across passes.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_code_scrubber #(
    parameter int               ADDR_W = 4,
    parameter int               DATA_W = 8,
    parameter int               CRC_W  = 4,
    parameter logic [CRC_W-1:0] POLY   = 4'b0011
) (
    input  wire                 clk,
    input  wire                 rst,
    crc_code_scrubber_if.slave  bus
);
    localparam int                  c_cw       = DATA_W + CRC_W;
    localparam int                  c_cnt_w    = $clog2(c_cw);
    localparam logic [c_cnt_w-1:0]  c_last_bit = c_cnt_w'(c_cw - 1);
    localparam logic [ADDR_W-1:0]   c_addr_max = '1;
    localparam logic [4:0]          c_cnt_sat  = 5'd31;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_req   = 3'd1;
    localparam logic [2:0] c_st_capt  = 3'd2;
    localparam logic [2:0] c_st_shift = 3'd3;
    localparam logic [2:0] c_st_check = 3'd4;

    // Where the FSM goes after checking the last address.
`ifdef CRC_SCRUB_CONTINUOUS_EN
    localparam logic [2:0] c_st_after_last = c_st_req;
`else
    localparam logic [2:0] c_st_after_last = c_st_idle;
`endif

    logic [2:0]         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [c_cw-1:0]    r_shift;
    logic [CRC_W-1:0]   r_rem;
    logic [c_cnt_w-1:0] r_bitcnt;
    logic               r_err_pulse;
    logic               r_done;
    logic [ADDR_W-1:0]  r_err_addr;
    logic [CRC_W-1:0]   r_err_syn;
    logic [4:0]         r_err_cnt;

    logic               w_fb;
    logic [CRC_W-1:0]   w_rem_next;

    // One step of the serial CRC division; the implicit x^CRC_W term of the
    // generator is represented by the feedback bit.
    assign w_fb       = r_rem[CRC_W-1] ^ r_shift[c_cw-1];
    assign w_rem_next = {r_rem[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);

    // The read request must drop in the very cycle the host takes the port,
    // so it is decoded from the registered state and the live mem_busy.
    assign bus.rd_en        = (r_state == c_st_req) && !bus.mem_busy;
    assign bus.rd_addr      = r_addr;
    assign bus.scrub_busy   = (r_state != c_st_idle);
    assign bus.scrub_done   = r_done;
    assign bus.err_pulse    = r_err_pulse;
    assign bus.err_addr     = r_err_addr;
    assign bus.err_syndrome = r_err_syn;
    assign bus.err_count    = r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_addr      <= '0;
            r_shift     <= '0;
            r_rem       <= '0;
            r_bitcnt    <= '0;
            r_err_pulse <= 1'b0;
            r_done      <= 1'b0;
            r_err_addr  <= '0;
            r_err_syn   <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            r_done      <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    // stop outranks start while idle
                    if (bus.start && !bus.stop) begin
                        r_state    <= c_st_req;
                        r_addr     <= '0;
                        r_err_addr <= '0;
                        r_err_syn  <= '0;
                        r_err_cnt  <= '0;
                    end
                end

                c_st_req: begin
                    if (bus.stop) begin
                        r_state <= c_st_idle;
                    end else if (!bus.mem_busy) begin
                        r_state <= c_st_capt;
                    end
                end

                c_st_capt: begin
                    if (bus.stop) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_shift  <= bus.rd_data;
                        r_rem    <= '0;
                        r_bitcnt <= c_last_bit;
                        r_state  <= c_st_shift;
                    end
                end

                c_st_shift: begin
                    if (bus.stop) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_shift <= {r_shift[c_cw-2:0], 1'b0};
                        r_rem   <= w_rem_next;
                        if (r_bitcnt == '0) begin
                            r_state <= c_st_check;
                        end else begin
                            r_bitcnt <= r_bitcnt - 1'b1;
                        end
                    end
                end

                c_st_check: begin
                    // A stop here drops both the word report and scrub_done.
                    if (bus.stop) begin
                        r_state <= c_st_idle;
                    end else begin
                        if (r_rem != '0) begin
                            r_err_pulse <= 1'b1;
                            r_err_addr  <= r_addr;
                            r_err_syn   <= r_rem;
                            if (r_err_cnt != c_cnt_sat) begin
                                r_err_cnt <= r_err_cnt + 1'b1;
                            end
                        end
                        if (r_addr == c_addr_max) begin
                            r_done  <= 1'b1;
                            r_addr  <= '0;
                            r_state <= c_st_after_last;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= c_st_req;
                        end
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_crc_code_scrubber.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crc_code_scrubber
//  Description : Self-checking bench for crc_code_scrubber. A timeline model
//                derives, from polynomial remainders and per-word stall
//                counts, what every output must be on every cycle of a pass.
//                Honours CRC_SCRUB_CONTINUOUS_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_code_scrubber;
    localparam int MAXC = 1100;
    localparam int MAXW = 80;

`ifdef CRC_SCRUB_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crc_code_scrubber_if #(.ADDR_W(4), .DATA_W(8), .CRC_W(4)) bus ();

    crc_code_scrubber #(
        .ADDR_W(4), .DATA_W(8), .CRC_W(4), .POLY(4'b0011)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory: registered read, data valid the cycle after rd_en.
    logic [11:0] mem [16];
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    int          stall [MAXW];
    int          errors = 0;
    int          checks = 0;
    int          done_edge;

    bit          e_rden  [MAXC];
    bit          e_busy  [MAXC];
    bit          e_pulse [MAXC];
    bit          e_done  [MAXC];
    bit          d_mbusy [MAXC];
    bit          d_start [MAXC];
    logic [3:0]  e_raddr [MAXC];
    logic [3:0]  e_eaddr [MAXC];
    logic [3:0]  e_syn   [MAXC];
    logic [4:0]  e_cnt   [MAXC];

    // Remainder of v(x) modulo x^4+x+1 by long division.
    function automatic logic [3:0] gf_mod(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 15; i >= 4; i--)
            if (r[i]) r = r ^ (16'h0013 << (i - 4));
        return r[3:0];
    endfunction

    function automatic logic [11:0] good_word(input logic [7:0] d);
        return {d, gf_mod({4'b0000, d, 4'b0000})};
    endfunction

    // The serial check with zero initial remainder yields C(x)*x^4 mod g(x).
    function automatic logic [3:0] syndrome(input logic [11:0] cw);
        return gf_mod({cw, 4'b0000});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Build the per-cycle expectation for a pass started at edge 0.
    // Cycle c is the interval between edge c-1 and edge c.
    task automatic build(input int sc, input int ncyc);
        int         t, w, s, r, ck, busy_until;
        bit         fin;
        logic [3:0] a, ea, es, sy;
        logic [4:0] ec;
        bit         upd [MAXC];
        logic [3:0] ua  [MAXC];
        logic [3:0] us  [MAXC];
        for (int c = 0; c < MAXC; c++) begin
            e_rden[c]  = 1'b0; e_pulse[c] = 1'b0; e_done[c] = 1'b0;
            e_raddr[c] = 4'h0; upd[c] = 1'b0; ua[c] = 4'h0; us[c] = 4'h0;
            d_mbusy[c] = ($urandom_range(0, 3) == 0);
        end
        t = 0; w = 0; fin = 1'b0; busy_until = ncyc;
        while (!fin) begin
            a  = 4'(w % 16);
            s  = stall[w];
            r  = t + s + 1;          // cycle the read is issued
            ck = t + s + 15;         // CHECK cycle
            for (int c = t + 1; c < r; c++) d_mbusy[c] = 1'b1;
            d_mbusy[r] = 1'b0;
            if (sc == 0 || r <= sc) begin
                e_rden[r]  = 1'b1;
                e_raddr[r] = a;
            end
            if (sc > 0 && sc <= ck) begin
                fin = 1'b1;
                busy_until = sc;
            end else begin
                sy = syndrome(mem[a]);
                if (sy != 4'h0) begin
                    upd[ck+1] = 1'b1; ua[ck+1] = a; us[ck+1] = sy;
                end
                if (a == 4'hF) begin
                    e_done[ck+1] = 1'b1;
                    if (!CONT) begin
                        fin = 1'b1;
                        busy_until = ck;
                    end
                end
                t = ck;
                w++;
                if (t >= ncyc || w >= MAXW) fin = 1'b1;
            end
        end
        ea = 4'h0; es = 4'h0; ec = 5'd0;
        for (int c = 1; c <= ncyc; c++) begin
            if (upd[c]) begin
                ea = ua[c]; es = us[c];
                ec = (ec == 5'd31) ? 5'd31 : ec + 5'd1;
            end
            e_pulse[c] = upd[c];
            e_eaddr[c] = ea; e_syn[c] = es; e_cnt[c] = ec;
            e_busy[c]  = (c <= busy_until);
            d_start[c] = e_busy[c] ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    task automatic compare(input string tag, input int c);
        string p;
        p = $sformatf("%s c%0d", tag, c);
        chk({p, " scrub_busy"},   32'(bus.scrub_busy),   32'(e_busy[c]));
        chk({p, " rd_en"},        32'(bus.rd_en),        32'(e_rden[c]));
        if (e_rden[c])
            chk({p, " rd_addr"},  32'(bus.rd_addr),      32'(e_raddr[c]));
        chk({p, " scrub_done"},   32'(bus.scrub_done),   32'(e_done[c]));
        chk({p, " err_pulse"},    32'(bus.err_pulse),    32'(e_pulse[c]));
        chk({p, " err_addr"},     32'(bus.err_addr),     32'(e_eaddr[c]));
        chk({p, " err_syndrome"}, 32'(bus.err_syndrome), 32'(e_syn[c]));
        chk({p, " err_count"},    32'(bus.err_count),    32'(e_cnt[c]));
    endtask

    task automatic run(input string tag, input int sc, input int ncyc);
        build(sc, ncyc);
        done_edge = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.stop = 1'b0; bus.mem_busy = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            bus.start    = d_start[c];
            bus.stop     = (c == sc);
            bus.mem_busy = d_mbusy[c];
            #1;
            compare(tag, c);
            if (bus.scrub_done === 1'b1 && done_edge < 0) done_edge = c - 1;
            @(negedge clk);
        end
        bus.start = 1'b0; bus.stop = 1'b0; bus.mem_busy = 1'b0;
    endtask

    task automatic fill_good();
        for (int i = 0; i < 16; i++) mem[i] = good_word(8'($urandom_range(0, 255)));
    endtask

    task automatic clear_stalls();
        for (int i = 0; i < MAXW; i++) stall[i] = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " scrub_busy"},   32'(bus.scrub_busy),   32'd0);
        chk({tag, " rd_en"},        32'(bus.rd_en),        32'd0);
        chk({tag, " rd_addr"},      32'(bus.rd_addr),      32'd0);
        chk({tag, " scrub_done"},   32'(bus.scrub_done),   32'd0);
        chk({tag, " err_pulse"},    32'(bus.err_pulse),    32'd0);
        chk({tag, " err_addr"},     32'(bus.err_addr),     32'd0);
        chk({tag, " err_syndrome"}, 32'(bus.err_syndrome), 32'd0);
        chk({tag, " err_count"},    32'(bus.err_count),    32'd0);
    endtask

    initial begin
        int sc, ncyc, total, dflt_sc;
        rst = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.mem_busy = 1'b0;
        bus.rd_data = '0;
        dflt_sc = CONT ? 255 : 0;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Pin the model against hand-computed codewords
        chk("model good 0x00", 32'(good_word(8'h00)), 32'h000);
        chk("model good 0x01", 32'(good_word(8'h01)), 32'h013);
        chk("model good 0x80", 32'(good_word(8'h80)), 32'h80E);
        chk("model syn 0x80F", 32'(syndrome(12'h80F)), 32'h3);
        chk("model syn 0x80E", 32'(syndrome(12'h80E)), 32'h0);

        // A: all valid, no stalls
        clear_stalls();
        fill_good();
        mem[0] = 12'h000; mem[1] = 12'h013; mem[2] = 12'h80E;
        run("clean", dflt_sc, 260);
        chk("clean done edge", 32'(done_edge), 32'd240);
        chk("clean err_count", 32'(bus.err_count), 32'd0);

        // B: one flipped bit at address 5
        mem[5] = 12'h80F;
        run("addr5", dflt_sc, 260);
        chk("addr5 err_addr", 32'(bus.err_addr), 32'd5);
        chk("addr5 err_syndrome", 32'(bus.err_syndrome), 32'h3);
        chk("addr5 err_count", 32'(bus.err_count), 32'd1);

        // stop and start together while idle: stays idle, err_* untouched
        @(negedge clk);
        bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0;
        #1;
        chk("idle stop+start busy", 32'(bus.scrub_busy), 32'd0);
        chk("idle stop+start err_count", 32'(bus.err_count), 32'd1);
        chk("idle stop+start err_addr", 32'(bus.err_addr), 32'd5);

        // C: every word corrupt
        for (int i = 0; i < 16; i++) mem[i] = 12'h001;
        if (CONT) begin
            run("allbad2", 485, 490);
            chk("allbad2 err_count sat", 32'(bus.err_count), 32'd31);
        end else begin
            run("allbad", 0, 260);
            chk("allbad err_count", 32'(bus.err_count), 32'd16);
        end

        // D: seven stall cycles on address 0
        fill_good();
        clear_stalls();
        stall[0] = 7;
        run("stall7", dflt_sc, 270);
        chk("stall7 done edge", 32'(done_edge), 32'd247);
        stall[0] = 0;

        // Reset in the middle of a SHIFT with errors already logged
        for (int i = 0; i < 16; i++) mem[i] = 12'h001;
        run("prerst", 0, 100);
        chk("prerst err_count", 32'(bus.err_count), 32'd6);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;

        // Stop at cycle 100, then hold in idle
        fill_good();
        mem[3] = mem[3] ^ 12'h040;
        run("stop100", 100, 130);

        // Randomised passes
        for (int k = 0; k < 5; k++) begin
            fill_good();
            for (int i = 0; i < 16; i++)
                if ($urandom_range(0, 3) == 0) mem[i] = mem[i] ^ 12'(1 << $urandom_range(0, 11));
            for (int i = 0; i < MAXW; i++) stall[i] = $urandom_range(0, 3);
            total = 240;
            for (int i = 0; i < 16; i++) total += stall[i];
            if (CONT) begin
                sc = $urandom_range(5, 2 * total);
                ncyc = sc + 20;
            end else if ($urandom_range(0, 1) == 1) begin
                sc = $urandom_range(5, total - 1);
                ncyc = sc + 20;
            end else begin
                sc = 0;
                ncyc = total + 20;
            end
            run($sformatf("rand%0d", k), sc, ncyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/crc_code_scrubber.md
# crc_code_scrubber

Background memory scrubber for the CRC-protected 12-bit word store. The block is the read-side counterpart to the CRC encoder/write path. It walks every address of the memory, fetches each codeword through the memory read port, and recomputes the CRC-4 bit-serially. It reports every word whose remainder is non-zero. It sits beside the read controller on the memory's read port and yields that port whenever the host path is active.

## Interface
Parameters:
- ADDR_W, 4: address width; the scrub covers 2^ADDR_W words.
- DATA_W, 8: data bits per codeword.
- CRC_W, 4: CRC bits per codeword; the codeword is DATA_W+CRC_W = 12 bits.
- POLY, 4'b0011: generator polynomial x^4+x+1, with the implicit x^4 term dropped.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a scrub pass; sampled only in IDLE.
- stop  in  1  abort the current pass.
- mem_busy  in  1  the host read/write path owns the memory port; the scrubber must not issue a read.
- rd_en  out  1  read request, one cycle per word.
- rd_addr  out  ADDR_W  read address; held stable from REQ through CAPT.
- rd_data  in  DATA_W+CRC_W  codeword, valid the cycle after rd_en.
- scrub_busy  out  1  high in every state except IDLE.
- scrub_done  out  1  one-cycle pulse at the end of a complete pass.
- err_pulse  out  1  one-cycle pulse when a word fails the check.
- err_addr  out  ADDR_W  address of the most recent failing word.
- err_syndrome  out  CRC_W  non-zero remainder of the most recent failing word.
- err_count  out  5  number of failing words since start; saturates at 31.

Reset values: all outputs 0; FSM in IDLE; address counter 0.

## Operation
- Codeword layout: rd_data[11:4] holds the data and rd_data[3:0] holds the CRC. The CRC is the remainder of data·x^4 mod POLY, with initial value 0.
- Check: the 12-bit codeword is shifted in MSB first. Each step computes fb = rem[3]^bit, then rem <= {rem[2:0],0} ^ (fb ? POLY : 0). A valid word leaves rem == 0.
- FSM states: IDLE, REQ, CAPT, SHIFT, CHECK.
  - IDLE, start=1 → REQ. On this transition err_count, err_addr and err_syndrome clear and addr is set to 0.
  - REQ, mem_busy=1: hold with rd_en=0.
  - REQ, mem_busy=0: rd_en=1, then → CAPT.
  - CAPT: load rd_data into the shift register and clear rem to 0; set bit counter=11; → SHIFT.
  - SHIFT: shift one bit per cycle for 12 cycles; when bit counter = 0 → CHECK.
  - CHECK, rem≠0: err_pulse=1; err_addr<=addr; err_syndrome<=rem; err_count increments, saturating at 31.
  - CHECK, addr < max: addr++ and → REQ.
  - CHECK, addr = max: scrub_done=1, addr wraps to 0, → IDLE.
- stop=1 in any non-IDLE state → IDLE at the next edge.
  - A stop in CHECK suppresses that word's report and suppresses scrub_done.
  - err_* outputs hold their values after a stop.
- A start asserted while busy is ignored. If stop and start are both high in IDLE, stop wins and the block stays in IDLE.
- mem_busy is examined only in REQ. Once rd_en has been issued, the word completes regardless of mem_busy.

## Timing
- Per-word latency without stalls: 15 cycles (REQ 1 + CAPT 1 + SHIFT 12 + CHECK 1).
- Full 16-word pass without stalls: 240 cycles. scrub_done asserts on the 240th cycle after the start edge.
- Each cycle spent with mem_busy=1 in REQ adds exactly one cycle.
- err_pulse, err_addr and err_syndrome all update in the same CHECK cycle.
- A reset asserted mid-pass takes effect at the next edge; no pulses are emitted.

## Configuration
- CRC_SCRUB_CONTINUOUS_EN defined:
  - After the CHECK of the last address, the FSM goes to REQ with addr=0 instead of IDLE, and scrub_done still pulses.
  - err_count accumulates across passes; only start clears it.
  - Only stop or rst returns the block to IDLE.
- CRC_SCRUB_CONTINUOUS_EN undefined: single-pass behaviour as described under Operation.

## Test plan
- Memory preloaded with valid codewords (0x000, 0x013, 0x80E, …), start pulse → scrub_done at cycle 240; err_pulse never asserts; err_count=0.
- Address 5 holds 0x80F (bit 0 flipped), all other words valid → exactly one err_pulse; err_addr=5; err_syndrome=4'h3; err_count=1.
- All 16 words hold 0x001 → 16 err_pulses and err_count=16. Then rerun with CRC_SCRUB_CONTINUOUS_EN over 2 passes → err_count=31 (saturated).
- Hold mem_busy=1 for 7 cycles while in REQ for address 0 → rd_en stays 0 during the stall; scrub_done arrives at cycle 247.
- Assert stop at cycle 100 → IDLE next cycle; scrub_busy=0; no scrub_done; err_* hold their values. A following start restarts from address 0.
- Assert rst mid-SHIFT → all outputs 0 next cycle. A start in IDLE while stop=1 is ignored.
